// File: rtl/mojo_reg_bridge.sv
// Byte-serial register bridge: UART frames write a shadow array that commits atomically to rx_arr,
// or read tx_arr back out. Define MOJO_REG_BRIDGE_CHECKSUM_EN for the frame checksum byte.
module mojo_reg_bridge #(
    parameter int unsigned ADDR_SPACE     = 256,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned AW             = $clog2(ADDR_SPACE)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              ser_rx_data,
    input  logic                    ser_new_rx_data,
    input  logic                    ser_tx_busy,
    output logic [7:0]              ser_tx_data,
    output logic                    ser_new_tx_data,
    input  logic [8*ADDR_SPACE-1:0] tx_arr,
    output logic [8*ADDR_SPACE-1:0] rx_arr,
    output logic [ADDR_SPACE-1:0]   wr_mask,
    output logic                    new_rx,
    output logic                    rx_busy,
    output logic                    tx_busy,
    output logic                    err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

`ifdef MOJO_REG_BRIDGE_CHECKSUM_EN
    typedef enum logic [2:0] {
        StIdle, StGetAddr, StReceive, StCommit, StSend, StCheck, StSendSum
    } state_t;
`else
    typedef enum logic [2:0] {StIdle, StGetAddr, StReceive, StCommit, StSend} state_t;
`endif

    state_t                  state_q, state_d;
    logic                    write_q;
    logic [7:0]              cnt_q;
    logic [AW-1:0]           ptr_q;
    logic [TW-1:0]           timer_q;
    logic [8*ADDR_SPACE-1:0] shadow_q, rx_arr_q;
    logic [ADDR_SPACE-1:0]   mask_q, wr_mask_q;
    logic                    new_rx_q, err_q, rx_busy_q, tx_busy_q, tx_new_q;
    logic [7:0]              tx_data_q;
`ifdef MOJO_REG_BRIDGE_CHECKSUM_EN
    logic [7:0]              sum_q;
`endif

    logic       take_hdr, take_addr, wr_byte, do_commit, abort, issue, issue_sum, timed;
    logic       timeout, tx_ready, cnt_last;
    logic [7:0] tx_byte;

    assign timeout  = (timer_q == TW'(TIMEOUT_CYCLES - 1));
    // One idle cycle is forced after every strobe, giving the 2-cycle minimum spacing.
    assign tx_ready = !ser_tx_busy && !tx_new_q;
    assign cnt_last = (cnt_q == 8'd1);
    assign tx_byte  = tx_arr[{ptr_q, 3'b000} +: 8];

    always_comb begin
        state_d   = state_q;
        take_hdr  = 1'b0;
        take_addr = 1'b0;
        wr_byte   = 1'b0;
        do_commit = 1'b0;
        abort     = 1'b0;
        issue     = 1'b0;
        issue_sum = 1'b0;
        timed     = 1'b0;
        case (state_q)
            StIdle: begin
                if (ser_new_rx_data) begin
                    take_hdr = 1'b1;
                    state_d  = StGetAddr;
                end
            end
            StGetAddr: begin
                timed = 1'b1;
                if (ser_new_rx_data) begin
                    take_addr = 1'b1;
                    state_d   = write_q ? StReceive : StSend;
                end else if (timeout) begin
                    abort = 1'b1;
                end
            end
            StReceive: begin
                timed = 1'b1;
                if (ser_new_rx_data) begin
                    wr_byte = 1'b1;
`ifdef MOJO_REG_BRIDGE_CHECKSUM_EN
                    if (cnt_last) state_d = StCheck;
`else
                    if (cnt_last) state_d = StCommit;
`endif
                end else if (timeout) begin
                    abort = 1'b1;
                end
            end
`ifdef MOJO_REG_BRIDGE_CHECKSUM_EN
            StCheck: begin
                timed = 1'b1;
                if (ser_new_rx_data) begin
                    if (8'(sum_q + ser_rx_data) == 8'h00) state_d = StCommit;
                    else abort = 1'b1;
                end else if (timeout) begin
                    abort = 1'b1;
                end
            end
            StSendSum: begin
                if (tx_ready) begin
                    issue_sum = 1'b1;
                    state_d   = StIdle;
                end
            end
`endif
            StCommit: begin
                do_commit = 1'b1;
                state_d   = StIdle;
            end
            StSend: begin
                if (tx_ready) begin
                    issue = 1'b1;
`ifdef MOJO_REG_BRIDGE_CHECKSUM_EN
                    if (cnt_last) state_d = StSendSum;
`else
                    if (cnt_last) state_d = StIdle;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
        if (abort) state_d = StIdle;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            write_q   <= 1'b0;
            cnt_q     <= '0;
            ptr_q     <= '0;
            timer_q   <= '0;
            shadow_q  <= '0;
            rx_arr_q  <= '0;
            mask_q    <= '0;
            wr_mask_q <= '0;
            new_rx_q  <= 1'b0;
            err_q     <= 1'b0;
            rx_busy_q <= 1'b0;
            tx_busy_q <= 1'b0;
            tx_new_q  <= 1'b0;
            tx_data_q <= '0;
`ifdef MOJO_REG_BRIDGE_CHECKSUM_EN
            sum_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            new_rx_q  <= do_commit;
            err_q     <= abort;
            tx_new_q  <= issue | issue_sum;
            tx_data_q <= 8'h00;
            timer_q   <= (timed && !ser_new_rx_data && !abort) ? timer_q + 1'b1 : '0;
            if (take_hdr) begin
                write_q <= ser_rx_data[7];
                cnt_q   <= {ser_rx_data[6:0] == 7'd0, ser_rx_data[6:0]};
`ifdef MOJO_REG_BRIDGE_CHECKSUM_EN
                sum_q   <= ser_rx_data;
`endif
            end
            if (take_addr) begin
                ptr_q     <= ser_rx_data[AW-1:0];
                rx_busy_q <= write_q;
                tx_busy_q <= !write_q;
`ifdef MOJO_REG_BRIDGE_CHECKSUM_EN
                sum_q     <= write_q ? 8'(sum_q + ser_rx_data) : 8'h00;
`endif
            end
            if (wr_byte) begin
                shadow_q[{ptr_q, 3'b000} +: 8] <= ser_rx_data;
                mask_q[ptr_q] <= 1'b1;
                ptr_q <= ptr_q + 1'b1;
                cnt_q <= cnt_q - 8'd1;
`ifdef MOJO_REG_BRIDGE_CHECKSUM_EN
                sum_q <= 8'(sum_q + ser_rx_data);
`endif
            end
            if (issue) begin
                tx_data_q <= tx_byte;
                ptr_q     <= ptr_q + 1'b1;
                cnt_q     <= cnt_q - 8'd1;
`ifdef MOJO_REG_BRIDGE_CHECKSUM_EN
                sum_q     <= 8'(sum_q + tx_byte);
`else
                if (cnt_last) tx_busy_q <= 1'b0;
`endif
            end
`ifdef MOJO_REG_BRIDGE_CHECKSUM_EN
            if (issue_sum) begin
                tx_data_q <= 8'h00 - sum_q;
                tx_busy_q <= 1'b0;
            end
`endif
            if (do_commit) begin
                rx_arr_q  <= shadow_q;
                wr_mask_q <= mask_q;
                mask_q    <= '0;
                rx_busy_q <= 1'b0;
            end
            // Abort rolls the shadow back so the next frame starts from the committed image.
            if (abort) begin
                shadow_q  <= rx_arr_q;
                mask_q    <= '0;
                rx_busy_q <= 1'b0;
            end
        end
    end

    assign ser_tx_data     = tx_data_q;
    assign ser_new_tx_data = tx_new_q;
    assign rx_arr          = rx_arr_q;
    assign wr_mask         = wr_mask_q;
    assign new_rx          = new_rx_q;
    assign rx_busy         = rx_busy_q;
    assign tx_busy         = tx_busy_q;
    assign err             = err_q;

endmodule

// File: tb/tb_mojo_reg_bridge.sv
// Directed bench for mojo_reg_bridge: table of write frames plus hand-written read, timeout,
// checksum (when MOJO_REG_BRIDGE_CHECKSUM_EN is defined) and async-reset sequences.
module tb_mojo_reg_bridge;

    localparam int unsigned AS = 256;
    localparam int unsigned TO = 20;

    logic            clk = 1'b0;
    logic            rst;
    logic [7:0]      ser_rx_data;
    logic            ser_new_rx_data;
    logic            ser_tx_busy;
    logic [7:0]      ser_tx_data;
    logic            ser_new_tx_data;
    logic [8*AS-1:0] tx_arr;
    logic [8*AS-1:0] rx_arr;
    logic [AS-1:0]   wr_mask;
    logic            new_rx, rx_busy, tx_busy, err;

    mojo_reg_bridge #(.ADDR_SPACE(AS), .TIMEOUT_CYCLES(TO)) dut (
        .clk             (clk),
        .rst             (rst),
        .ser_rx_data     (ser_rx_data),
        .ser_new_rx_data (ser_new_rx_data),
        .ser_tx_busy     (ser_tx_busy),
        .ser_tx_data     (ser_tx_data),
        .ser_new_tx_data (ser_new_tx_data),
        .tx_arr          (tx_arr),
        .rx_arr          (rx_arr),
        .wr_mask         (wr_mask),
        .new_rx          (new_rx),
        .rx_busy         (rx_busy),
        .tx_busy         (tx_busy),
        .err             (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  hdr;
        logic [7:0]  addr;
        logic [31:0] data;     // byte k at [8k+7:8k]
        logic [7:0]  chk_idx;  // hand-picked byte to inspect after commit
        logic [7:0]  chk_val;
    } wvec_t;

    wvec_t      vecs [4];
    logic [7:0] model [AS];
    logic [7:0] wbuf [128];
    logic [7:0] strobe_q [$];
    int checks = 0, errors = 0, cyc = 0;
    int new_rx_cnt = 0, err_cnt = 0, last_strobe = -10;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (new_rx) new_rx_cnt++;
        if (err) err_cnt++;
        if (new_rx || err) begin
            checks++;
            if (new_rx && err) begin
                errors++;
                $display("FAIL pulse_overlap: new_rx=%0b err=%0b, required not both", new_rx, err);
            end
        end
        checks++;
        if (ser_new_tx_data) begin
            strobe_q.push_back(ser_tx_data);
            if (cyc - last_strobe < 2) begin
                errors++;
                $display("FAIL tx_spacing: %0d cycles, required >= 2", cyc - last_strobe);
            end
            last_strobe = cyc;
        end else if (ser_tx_data !== 8'h00) begin
            errors++;
            $display("FAIL tx_data_idle: got %0h, required 00", ser_tx_data);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_arr(input string name);
        int bad = -1;
        for (int i = 0; i < AS; i++)
            if (bad < 0 && rx_arr[8*i +: 8] !== model[i]) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s: rx_arr byte %0d got %0h, expected %0h", name, bad,
                     rx_arr[8*bad +: 8], model[bad]);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        ser_rx_data     = b;
        ser_new_rx_data = 1'b1;
        @(negedge clk);
        ser_new_rx_data = 1'b0;
        ser_rx_data     = 8'h00;
    endtask

    // Sends a full write frame from wbuf and checks commit timing, array and mask.
    task automatic do_write(input logic [7:0] hdr, input logic [7:0] addr, input string tag);
        int n, nrx0, idx;
        logic [7:0] sum;
        logic [AS-1:0] emask;
        n     = (hdr[6:0] == 7'd0) ? 128 : int'(hdr[6:0]);
        nrx0  = new_rx_cnt;
        sum   = hdr + addr;
        emask = '0;
        send_byte(hdr);
        send_byte(addr);
        chk({tag, " rx_busy"}, 32'(rx_busy), 32'd1);
        for (int k = 0; k < n; k++) begin
            send_byte(wbuf[k]);
            sum = sum + wbuf[k];
        end
`ifdef MOJO_REG_BRIDGE_CHECKSUM_EN
        send_byte(8'h00 - sum);
`endif
        chk({tag, " new_rx early"}, 32'(new_rx), 32'd0);
        chk_arr({tag, " pre-commit"});
        for (int k = 0; k < n; k++) begin
            idx = (int'(addr) + k) % AS;
            model[idx] = wbuf[k];
            emask[idx] = 1'b1;
        end
        @(negedge clk);
        chk({tag, " new_rx"}, 32'(new_rx), 32'd1);
        chk_arr({tag, " commit"});
        checks++;
        if (wr_mask !== emask) begin
            errors++;
            $display("FAIL %s wr_mask: got %h, expected %h", tag, wr_mask, emask);
        end
        chk({tag, " rx_busy end"}, 32'(rx_busy), 32'd0);
        @(negedge clk);
        chk({tag, " new_rx one-shot"}, 32'(new_rx), 32'd0);
        chk({tag, " new_rx count"}, 32'(new_rx_cnt - nrx0), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, e0, n0;
        rst = 1'b1;
        ser_rx_data = 8'h00;
        ser_new_rx_data = 1'b0;
        ser_tx_busy = 1'b0;
        for (int i = 0; i < AS; i++) begin
            tx_arr[8*i +: 8] = 8'(i * 7 + 3);
            model[i] = 8'h00;
        end
        vecs[0] = '{8'h83, 8'h10, 32'h00CCBBAA, 8'h12, 8'hCC};
        vecs[1] = '{8'h82, 8'hFF, 32'h00002211, 8'h00, 8'h22};
        vecs[2] = '{8'h84, 8'hFE, 32'h04030201, 8'h01, 8'h04};
        vecs[3] = '{8'h81, 8'h11, 32'h0000005E, 8'h10, 8'hAA};

        repeat (3) @(negedge clk);
        chk_arr("reset rx_arr");
        chk("reset wr_mask", 32'(wr_mask != '0), 32'd0);
        chk("reset flags", {26'd0, new_rx, err, rx_busy, tx_busy, ser_new_tx_data, 1'b0}, 32'd0);
        chk("reset tx_data", 32'(ser_tx_data), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            for (int k = 0; k < 4; k++) wbuf[k] = vecs[v].data[8*k +: 8];
            do_write(vecs[v].hdr, vecs[v].addr, $sformatf("vec%0d", v));
            chk($sformatf("vec%0d byte", v), 32'(rx_arr[8*vecs[v].chk_idx +: 8]),
                32'(vecs[v].chk_val));
        end

        // Read 2 bytes from 5 while the transmitter is busy; a stray byte mid-read is dropped.
        strobe_q.delete();
        ser_tx_busy = 1'b1;
        send_byte(8'h02);
        send_byte(8'h05);
        chk("read tx_busy", 32'(tx_busy), 32'd1);
        send_byte(8'h83);
        repeat (8) @(negedge clk);
        chk("read held strobes", 32'(strobe_q.size()), 32'd0);
        ser_tx_busy = 1'b0;
        @(negedge clk);
        chk("read first strobe", 32'(ser_new_tx_data), 32'd1);
        chk("read first data", 32'(ser_tx_data), 32'h26);
        w = 0;
        while (tx_busy && w < 30) begin
            @(negedge clk);
            w++;
        end
        chk("read tx_busy fall", 32'(tx_busy), 32'd0);
        repeat (3) @(negedge clk);
`ifdef MOJO_REG_BRIDGE_CHECKSUM_EN
        chk("read strobe count", 32'(strobe_q.size()), 32'd3);
        if (strobe_q.size() == 3) chk("read sum byte", 32'(strobe_q[2]), 32'hAD);
`else
        chk("read strobe count", 32'(strobe_q.size()), 32'd2);
`endif
        if (strobe_q.size() >= 2) begin
            chk("read byte5", 32'(strobe_q[0]), 32'h26);
            chk("read byte6", 32'(strobe_q[1]), 32'h2D);
        end

        // Inter-byte timeout after one data byte of a two-byte write.
        e0 = err_cnt;
        n0 = new_rx_cnt;
        send_byte(8'h82);
        send_byte(8'h00);
        send_byte(8'h55);
        chk("timeout rx_busy", 32'(rx_busy), 32'd1);
        repeat (TO - 1) @(negedge clk);
        chk("timeout not early", 32'(err), 32'd0);
        @(negedge clk);
        chk("timeout err", 32'(err), 32'd1);
        chk("timeout rx_busy clr", 32'(rx_busy), 32'd0);
        @(negedge clk);
        chk("timeout err one-shot", 32'(err), 32'd0);
        @(negedge clk);
        chk("timeout err count", 32'(err_cnt - e0), 32'd1);
        chk("timeout no new_rx", 32'(new_rx_cnt - n0), 32'd0);
        chk_arr("timeout rx_arr");

        // LEN=0 means 128 bytes; frame follows the aborted one.
        for (int k = 0; k < 128; k++) wbuf[k] = 8'(k + 1);
        do_write(8'h80, 8'h40, "len128");
        chk("len128 first", 32'(rx_arr[8*8'h40 +: 8]), 32'h01);
        chk("len128 last", 32'(rx_arr[8*8'hBF +: 8]), 32'h80);
        chk("len128 after", 32'(rx_arr[8*8'hC0 +: 8]), 32'h00);

`ifdef MOJO_REG_BRIDGE_CHECKSUM_EN
        wbuf[0] = 8'h10;
        do_write(8'h81, 8'h04, "csum good");
        chk("csum good byte4", 32'(rx_arr[8*4 +: 8]), 32'h10);
        wbuf[0] = 8'h99;
        e0 = err_cnt;
        n0 = new_rx_cnt;
        send_byte(8'h81);
        send_byte(8'h04);
        send_byte(8'h99);
        send_byte(8'h6C);
        chk("csum bad err", 32'(err), 32'd1);
        repeat (3) @(negedge clk);
        chk("csum bad err count", 32'(err_cnt - e0), 32'd1);
        chk("csum bad no new_rx", 32'(new_rx_cnt - n0), 32'd0);
        chk("csum bad byte4", 32'(rx_arr[8*4 +: 8]), 32'h10);
        chk_arr("csum bad rx_arr");
`endif

        // Asynchronous reset in the middle of RECEIVE.
        e0 = err_cnt;
        n0 = new_rx_cnt;
        send_byte(8'h84);
        send_byte(8'h20);
        send_byte(8'h01);
        chk("rst pre rx_busy", 32'(rx_busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < AS; i++) model[i] = 8'h00;
        chk_arr("rst rx_arr");
        chk("rst wr_mask", 32'(wr_mask != '0), 32'd0);
        chk("rst flags", {26'd0, new_rx, err, rx_busy, tx_busy, ser_new_tx_data, 1'b0}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst no pulses", 32'((err_cnt - e0) + (new_rx_cnt - n0)), 32'd0);
        wbuf[0] = 8'h5A;
        do_write(8'h81, 8'h20, "post-rst");
        chk("post-rst byte", 32'(rx_arr[8*8'h20 +: 8]), 32'h5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
